oai222_arc_sequencer: RTL and testbench
=======================================

Name: oai222_arc_sequencer

Overview:
- On-chip stimulus and check stage that sits directly upstream of a 9-track oai222 cell instance and consumes its ZN output.
- Walks every sensitised timing arc of ZN = !((A1|A2)&(B1|B2)&(C1|C2)): 6 pins × 9 side conditions = 54 arcs, each driven low then high.
- Samples ZN after a programmable settle time and compares it with the expected value.
- Counts mismatches and captures the first failing arc; used for library bring-up and silicon arc screening.

Parameters:
- SETTLE_CYCLES, 2, clock cycles from a drive-vector update to the ZN_IN sample; legal range 1..15.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- START  input  1  one-cycle run request; honoured only when BUSY=0
- ABORT  input  1  synchronous run cancel
- DRV  output  6  registered cell inputs {A1,A2,B1,B2,C1,C2}, MSB=A1
- ZN_IN  input  1  ZN from the driven oai222 instance
- BUSY  output  1  run in progress
- DONE  output  1  sticky run-complete flag
- ERR  output  1  sticky; at least one mismatch in this run
- ERR_CNT  output  ERR_W  mismatch count, saturates at all-ones
- FAIL_ARC  output  6  arc index (0..53) of the first mismatch
- FAIL_PH  output  1  phase of the first mismatch: 0 = target low, 1 = target high
- ARC_IDX  output  6  arc currently driven

Behaviour:
- Reset (RN=0, asynchronous): DRV=0, BUSY=0, DONE=0, ERR=0, ERR_CNT=0, FAIL_ARC=0, FAIL_PH=0, ARC_IDX=0, FSM=IDLE. Effective at any point, including mid-run.
- Arc index: arc = pin*9 + cond. Pin order is A1,A2,B1,B2,C1,C2.
- Side pairs:
  - Partner pin in the target's pair is held 0.
  - The two other pairs are ordered A,B,C with the target pair skipped.
  - First pair = ENC[cond/3], second pair = ENC[cond%3], where ENC = {01,10,11} (first bit = pin1).
- Expected ZN: 1 while the target pin is 0; 0 while the target pin is 1.
- FSM states: IDLE, LO_WAIT, HI_WAIT, FIN. The settle counter reloads to SETTLE_CYCLES-1 on every drive update.
- IDLE:
  - START=1 moves to LO_WAIT at the next edge.
  - That edge also clears DONE, ERR, ERR_CNT, FAIL_*; loads the arc-0 low vector; sets BUSY=1 and ARC_IDX=0.
- LO_WAIT: when the counter reaches 0, that edge samples ZN_IN against 1, drives the target pin to 1 and moves to HI_WAIT.
- HI_WAIT: when the counter reaches 0, that edge samples ZN_IN against 0.
  - If arc < 53: load the next arc's low vector, increment ARC_IDX, return to LO_WAIT.
  - Else: go to FIN.
- FIN: entered on the final sample edge. That edge sets DRV=0, BUSY=0, DONE=1. FSM returns to IDLE next cycle; DONE holds until the next START or reset.
- Run length: BUSY is high for exactly 108*SETTLE_CYCLES cycles (216 at the default).
- Mismatch on a sample edge:
  - ERR_CNT increments (saturating) and ERR is set.
  - If this is the first mismatch of the run, FAIL_ARC and FAIL_PH are captured.
  - In simulation, an X or Z on ZN_IN counts as a mismatch.
- ABORT=1 while BUSY:
  - Next edge sets DRV=0, BUSY=0, FSM=IDLE; DONE stays 0.
  - ERR, ERR_CNT and FAIL_* keep their values.
  - ABORT has priority over a coincident sample edge; that sample is discarded.
- START while BUSY=1 is ignored. START and ABORT together in IDLE: START wins.
- DRV changes only on clock edges and is glitch-free. Only one DRV bit toggles between the low and high phases of an arc.

Decomposition:
- Package oai222_seq_pkg:
  - state enum;
  - NUM_ARCS=54, NUM_COND=9;
  - pin index constants;
  - the ENC side-pair table;
  - DRV bit-position constants.
- Sub-module oai222_arc_pattern: purely combinational, maps (arc, phase) to {drive vector, expected ZN}. The sequencer owns the FSM, counters and capture logic.

Test Plan:
- Reset: RN=0 mid-sequence → all outputs at reset values asynchronously. After release with no START, DRV stays 6'b000000.
- Golden run: behavioural oai222 model on DRV/ZN_IN, SETTLE_CYCLES=2, START pulse.
  - Arc 0 drives 6'b000101 then 6'b100101.
  - Arc 53 drives 6'b111100 then 6'b111101.
  - BUSY high 216 cycles, then DONE=1, ERR=0, ERR_CNT=0.
- ZN_IN tied 1 → ERR_CNT=54, ERR=1, FAIL_ARC=0, FAIL_PH=1, DONE=1.
- ZN_IN tied 0 → ERR_CNT=54, FAIL_ARC=0, FAIL_PH=0.
- ABORT on ARC_IDX=30 → next cycle BUSY=0, DRV=0, DONE=0.
  - START pulsed during the run is ignored.
  - A fresh START restarts at arc 0 and clears ERR_CNT.
- Model with pin B2 stuck at 0, SETTLE_CYCLES=1:
  - Failing arcs are 27..35 (B2 as target) in the high phase, plus side conditions where the B pair is 01.
  - FAIL_ARC=0, FAIL_PH=1. With the model fixed, BUSY is high for 108 cycles.

Source files
------------

// File: rtl/oai222_arc_sequencer_pkg.sv
// Shared types and constants for the oai222 timing-arc sequencer.
package oai222_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LO_WAIT = 2'd1,
    HI_WAIT = 2'd2,
    FIN     = 2'd3
  } seq_state_t;

  localparam int NUM_ARCS = 54;
  localparam int NUM_COND = 9;

  // Pin order used by the arc numbering: arc = pin*9 + cond
  localparam int PIN_A1 = 0;
  localparam int PIN_A2 = 1;
  localparam int PIN_B1 = 2;
  localparam int PIN_B2 = 3;
  localparam int PIN_C1 = 4;
  localparam int PIN_C2 = 5;

  // Bit positions of each cell input inside the drive vector (A1 is the MSB)
  localparam int DRV_A1 = 5;
  localparam int DRV_A2 = 4;
  localparam int DRV_B1 = 3;
  localparam int DRV_B2 = 2;
  localparam int DRV_C1 = 1;
  localparam int DRV_C2 = 0;

  // Side-pair encoding {pin1,pin2}; every entry keeps its pair's OR at 1
  function automatic logic [1:0] enc_pair(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'b01;
      2'd1:    return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/oai222_arc_sequencer_if.sv
// Control/status and cell-side bundle of the arc sequencer.
interface oai222_arc_sequencer_if #(
  parameter int ERR_W = 8
) ();
  logic             START;
  logic             ABORT;
  logic [5:0]       DRV;
  logic             ZN_IN;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [ERR_W-1:0] ERR_CNT;
  logic [5:0]       FAIL_ARC;
  logic             FAIL_PH;
  logic [5:0]       ARC_IDX;

  modport master (
    output START, ABORT, ZN_IN,
    input  DRV, BUSY, DONE, ERR, ERR_CNT, FAIL_ARC, FAIL_PH, ARC_IDX
  );

  modport slave (
    input  START, ABORT, ZN_IN,
    output DRV, BUSY, DONE, ERR, ERR_CNT, FAIL_ARC, FAIL_PH, ARC_IDX
  );
endinterface

// File: rtl/oai222_arc_pattern.sv
// Combinational map from (arc, phase) to the oai222 drive vector and expected ZN.
module oai222_arc_pattern
  import oai222_seq_pkg::*;
(
  input  logic [5:0] arc,
  input  logic       phase,
  output logic [5:0] drive,
  output logic       exp_zn
);

  logic [2:0]      pin;
  logic [3:0]      cond;
  logic [1:0]      tpair;
  logic [1:0]      first_pair;
  logic [1:0]      second_pair;
  logic [2:0][1:0] pair_val;
  logic [5:0]      pv;

  // Decode the arc, fill the target pair and the two side pairs, then place pins
  always_comb begin
    pin   = 3'(arc / 6'(NUM_COND));
    cond  = 4'(arc % 6'(NUM_COND));
    tpair = pin[2:1];
    case (tpair)
      2'd0:    begin first_pair = 2'd1; second_pair = 2'd2; end
      2'd1:    begin first_pair = 2'd0; second_pair = 2'd2; end
      default: begin first_pair = 2'd0; second_pair = 2'd1; end
    endcase
    for (int k = 0; k < 3; k++) begin
      if (2'(k) == tpair)
        pair_val[k] = pin[0] ? {1'b0, phase} : {phase, 1'b0};
      else if (2'(k) == first_pair)
        pair_val[k] = enc_pair(2'(cond / 4'd3));
      else
        pair_val[k] = enc_pair(2'(cond % 4'd3));
    end
    pv = {pair_val[2][0], pair_val[2][1], pair_val[1][0],
          pair_val[1][1], pair_val[0][0], pair_val[0][1]};
    drive         = '0;
    drive[DRV_A1] = pv[PIN_A1];
    drive[DRV_A2] = pv[PIN_A2];
    drive[DRV_B1] = pv[PIN_B1];
    drive[DRV_B2] = pv[PIN_B2];
    drive[DRV_C1] = pv[PIN_C1];
    drive[DRV_C2] = pv[PIN_C2];
    exp_zn        = ~phase;
  end

endmodule

// File: rtl/oai222_arc_sequencer.sv
// Walks all 54 oai222 timing arcs low then high, samples ZN after a settle
// time and records mismatches.
module oai222_arc_sequencer
  import oai222_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input logic                   CLK,
  input logic                   RN,
  oai222_arc_sequencer_if.slave bus
);

  localparam logic [3:0] RELOAD   = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0] LAST_ARC = 6'(NUM_ARCS - 1);

  seq_state_t       state_q, state_n;
  logic [3:0]       cnt_q, cnt_n;
  logic [5:0]       arc_q, arc_n;
  logic [5:0]       drv_q, drv_n;
  logic             exp_q, exp_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             sample_en, run_clr, mismatch;
  logic [5:0]       pat_arc, pat_drv;
  logic             pat_ph, pat_exp;
  logic             err_q, fail_ph_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [5:0]       fail_arc_q;

  // Select which arc/phase vector would be loaded on the next drive update
  always_comb begin
    pat_arc = arc_q;
    pat_ph  = 1'b0;
    case (state_q)
      IDLE:    pat_arc = '0;
      LO_WAIT: pat_ph  = 1'b1;
      HI_WAIT: pat_arc = arc_q + 6'd1;
      default: pat_arc = arc_q;
    endcase
  end

  oai222_arc_pattern u_pattern (
    .arc    (pat_arc),
    .phase  (pat_ph),
    .drive  (pat_drv),
    .exp_zn (pat_exp)
  );

  // Next-state, settle counter, drive vector and run flags
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    arc_n     = arc_q;
    drv_n     = drv_q;
    exp_n     = exp_q;
    busy_n    = busy_q;
    done_n    = done_q;
    sample_en = 1'b0;
    run_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_n = LO_WAIT;
          cnt_n   = RELOAD;
          arc_n   = '0;
          drv_n   = pat_drv;
          exp_n   = pat_exp;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          run_clr = 1'b1;
        end
      end
      LO_WAIT, HI_WAIT: begin
        if (bus.ABORT) begin
          state_n = IDLE;
          drv_n   = '0;
          busy_n  = 1'b0;
        end else if (cnt_q == 4'd0) begin
          sample_en = 1'b1;
          if (state_q == LO_WAIT || arc_q != LAST_ARC) begin
            state_n = (state_q == LO_WAIT) ? HI_WAIT : LO_WAIT;
            cnt_n   = RELOAD;
            drv_n   = pat_drv;
            exp_n   = pat_exp;
            if (state_q == HI_WAIT) arc_n = arc_q + 6'd1;
          end else begin
            state_n = FIN;
            drv_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // X or Z on ZN_IN must read as a failure, hence the case inequality
  assign mismatch = sample_en && (bus.ZN_IN !== exp_q);

  // Sequencer registers
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      arc_q   <= '0;
      drv_q   <= '0;
      exp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      arc_q   <= arc_n;
      drv_q   <= drv_n;
      exp_q   <= exp_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Mismatch counting and first-failure capture
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      fail_arc_q <= '0;
      fail_ph_q  <= 1'b0;
    end else if (run_clr) begin
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      fail_arc_q <= '0;
      fail_ph_q  <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
      if (!err_q) begin
        fail_arc_q <= arc_q;
        fail_ph_q  <= (state_q == HI_WAIT);
      end
    end
  end

  assign bus.DRV      = drv_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.ERR_CNT  = err_cnt_q;
  assign bus.FAIL_ARC = fail_arc_q;
  assign bus.FAIL_PH  = fail_ph_q;
  assign bus.ARC_IDX  = arc_q;

endmodule

// File: tb/tb_oai222_arc_sequencer.sv
// Scoreboard bench for oai222_arc_sequencer: two instances (settle 2 / ERR_W 8
// and settle 1 / ERR_W 6) driven by a behavioural oai222 cell with fault modes.
module tb_oai222_arc_sequencer;

  logic clk = 1'b0;
  logic rn;
  logic start, abort, sel;
  int   mode;       // 0 good cell, 1 ZN=1, 2 ZN=0, 3 B2 stuck-0, 4 inverted cell
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  oai222_arc_sequencer_if #(.ERR_W(8)) bus0 ();
  oai222_arc_sequencer_if #(.ERR_W(6)) bus1 ();

  oai222_arc_sequencer #(.SETTLE_CYCLES(2), .ERR_W(8)) dut0 (.CLK(clk), .RN(rn), .bus(bus0.slave));
  oai222_arc_sequencer #(.SETTLE_CYCLES(1), .ERR_W(6)) dut1 (.CLK(clk), .RN(rn), .bus(bus1.slave));

  function automatic logic zn_model(input logic [5:0] d, input int m);
    logic [5:0] x;
    logic       g;
    x = d;
    if (m == 3) x[2] = 1'b0;
    g = !((x[5] | x[4]) & (x[3] | x[2]) & (x[1] | x[0]));
    case (m)
      1:       return 1'b1;
      2:       return 1'b0;
      4:       return !g;
      default: return g;
    endcase
  endfunction

  assign bus0.ZN_IN = zn_model(bus0.DRV, mode);
  assign bus1.ZN_IN = zn_model(bus1.DRV, mode);
  assign bus0.START = start & ~sel;
  assign bus1.START = start & sel;
  assign bus0.ABORT = abort & ~sel;
  assign bus1.ABORT = abort & sel;

  logic [5:0] m_drv, m_arc, m_fa;
  logic       m_busy, m_done, m_err, m_fp;
  logic [7:0] m_cnt;
  assign m_drv  = sel ? bus1.DRV      : bus0.DRV;
  assign m_arc  = sel ? bus1.ARC_IDX  : bus0.ARC_IDX;
  assign m_fa   = sel ? bus1.FAIL_ARC : bus0.FAIL_ARC;
  assign m_busy = sel ? bus1.BUSY     : bus0.BUSY;
  assign m_done = sel ? bus1.DONE     : bus0.DONE;
  assign m_err  = sel ? bus1.ERR      : bus0.ERR;
  assign m_fp   = sel ? bus1.FAIL_PH  : bus0.FAIL_PH;
  assign m_cnt  = sel ? {2'b00, bus1.ERR_CNT} : bus0.ERR_CNT;

  typedef struct {
    logic       done;
    logic       err;
    logic [7:0] cnt;
    logic [5:0] fa;
    logic       fp;
    int         len;
  } status_t;

  status_t     st_q[$];
  logic [11:0] vec_q[$];   // {ARC_IDX, DRV}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event expected one", name);
  endtask

  // Drive vector of an arc from the arc definition (pin order A1..C2)
  function automatic logic [5:0] exp_vec(input int arc, input int ph);
    int pin, cond, tp, o0, o1, e0, e1;
    logic [5:0] p;
    pin  = arc / 9;
    cond = arc % 9;
    tp   = pin / 2;
    o0   = (tp == 0) ? 1 : 0;
    o1   = (tp == 2) ? 1 : 2;
    e0   = cond / 3 + 1;
    e1   = cond % 3 + 1;
    p    = '0;
    p[pin]    = (ph != 0);
    p[2*o0]   = e0[1];
    p[2*o0+1] = e0[0];
    p[2*o1]   = e1[1];
    p[2*o1+1] = e1[0];
    return {p[0], p[1], p[2], p[3], p[4], p[5]};
  endfunction

  task automatic plan_run(input int m, input int settle, input int ew, input int abort_at);
    status_t s;
    int      c;
    logic    first;
    logic [5:0] v;
    c = 0; first = 1'b1; s.fa = '0; s.fp = 1'b0;
    for (int a = 0; a < 54; a++) begin
      for (int ph = 0; ph < 2; ph++) begin
        v = exp_vec(a, ph);
        vec_q.push_back({6'(a), v});
        if ((abort_at < 0 || a < abort_at) && (zn_model(v, m) != (ph == 0))) begin
          c++;
          if (first) begin s.fa = 6'(a); s.fp = (ph != 0); first = 1'b0; end
        end
      end
    end
    s.cnt  = 8'((c > (1 << ew) - 1) ? (1 << ew) - 1 : c);
    s.err  = (c != 0);
    s.done = (abort_at < 0);
    s.len  = (abort_at < 0) ? 108 * settle : 0;
    st_q.push_back(s);
  endtask

  task automatic pulse_start(input logic with_abort);
    @(negedge clk); start = 1'b1; abort = with_abort;
    @(negedge clk); start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (m_busy === 1'b1 && n < max) begin @(negedge clk); n++; end
    if (m_busy === 1'b1) fail_event("busy_timeout");
    @(posedge clk);
  endtask

  task automatic wait_arc(input logic [5:0] t, input int max);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (m_arc != t && n < max);
    if (m_arc != t) fail_event("arc_timeout");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_drv"},  m_drv,  0);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_done"}, m_done, 0);
    check({tag, "_err"},  m_err,  0);
    check({tag, "_cnt"},  m_cnt,  0);
    check({tag, "_farc"}, m_fa,   0);
    check({tag, "_fph"},  m_fp,   0);
    check({tag, "_arc"},  m_arc,  0);
  endtask

  // Monitor: pops a vector on every drive update and a status at run end
  initial begin
    logic        pb;
    logic [5:0]  pd;
    int          dwell, blen;
    logic [11:0] ev;
    status_t     s;
    pb = 1'b0; pd = '0; dwell = 0; blen = 0;
    forever begin
      @(negedge clk);
      if (m_busy === 1'b1) begin
        blen++;
        if (!pb || m_drv != pd) begin
          if (vec_q.size() == 0) fail_event("extra_vector");
          else begin
            ev = vec_q.pop_front();
            check("drv", m_drv, ev[5:0]);
            check("arc_idx", m_arc, ev[11:6]);
            if (pb) check("dwell", dwell, sel ? 1 : 2);
          end
          dwell = 0;
        end
        dwell++;
      end else if (pb) begin
        if (st_q.size() == 0) fail_event("extra_run_end");
        else begin
          s = st_q.pop_front();
          check("done", m_done, s.done);
          check("err", m_err, s.err);
          check("err_cnt", m_cnt, s.cnt);
          check("fail_arc", m_fa, s.fa);
          check("fail_ph", m_fp, s.fp);
          check("drv_end", m_drv, 0);
          if (s.len != 0) check("busy_len", blen, s.len);
          check("vec_left", vec_q.size(), 0);
        end
        blen = 0;
      end
      pb = m_busy;
      pd = m_drv;
    end
  end

  initial begin
    status_t z;
    rn = 1'b0; start = 1'b0; abort = 1'b0; mode = 0; sel = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk); rn = 1'b1;

    // Good cell, tied-high, tied-low on the settle-2 instance
    for (int m = 0; m < 3; m++) begin
      mode = m;
      plan_run(m, 2, 8, -1);
      pulse_start(1'b0);
      wait_idle(400);
    end

    // Abort at arc 30 with a stray START at arc 10
    mode = 2;
    plan_run(2, 2, 8, 30);
    pulse_start(1'b0);
    wait_arc(6'd10, 100);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_arc(6'd30, 200);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    vec_q.delete();
    wait_idle(10);

    // Fresh run with START and ABORT together in IDLE
    mode = 0;
    plan_run(0, 2, 8, -1);
    pulse_start(1'b1);
    wait_idle(400);

    // Asynchronous reset in the middle of an erroring run
    mode = 2;
    plan_run(2, 2, 8, -1);
    pulse_start(1'b0);
    repeat (40) @(negedge clk);
    #2 rn = 1'b0;
    vec_q.delete();
    st_q.delete();
    z.done = 1'b0; z.err = 1'b0; z.cnt = '0; z.fa = '0; z.fp = 1'b0; z.len = 0;
    st_q.push_back(z);
    #1 check_zero("async_rst");
    @(negedge clk); rn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_drv", m_drv, 0);
    check("idle_busy", m_busy, 0);
    @(posedge clk);

    // Settle-1 instance: B2 stuck, good cell, inverted cell (saturation)
    sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mode = (k == 0) ? 3 : ((k == 1) ? 0 : 4);
      plan_run(mode, 1, 6, -1);
      pulse_start(1'b0);
      wait_idle(300);
    end

    repeat (3) @(negedge clk);
    check("final_vec_q", vec_q.size(), 0);
    check("final_st_q", st_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
